wb_scoreboard: RTL and testbench
================================

Name: wb_scoreboard

Overview:
- Register-write scoreboard: the issue/consume end of the MIPS pipeline writeback interface.
- The ID stage registers each destination-register write it issues; the WB stage (WB_RegWrite/WB_WriteReg) retires it.
- The block raises Stall while an ID-stage source register still has an unretired write in flight.
- Sits beside the controller in ID, gating the IF/ID and ID/EX pipeline registers.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is never tracked.
- CNT_W, 2, width of each per-register in-flight counter; max count = 2^CNT_W-1.
- STAT_W, 16, width of the stall-cycle statistic counter.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Flush  input  1  synchronous clear of all pending state
- IssueValid  input  1  an instruction is presented in ID this cycle
- IssueRegWrite  input  1  the ID instruction writes a register
- IssueWriteReg  input  5  destination register index of the ID instruction
- UseRs  input  1  the ID instruction reads rs
- UseRt  input  1  the ID instruction reads rt
- SrcRs  input  5  rs index
- SrcRt  input  5  rt index
- WB_RegWrite  input  1  write-enable at WB
- WB_WriteReg  input  5  register index retired at WB
- Stall  output  1  hold ID (combinational)
- PendingMask  output  NUM_REGS  bit r = (count[r] != 0); bit 0 always 0
- StallCycles  output  STAT_W  saturating count of cycles with Stall=1
- Underflow  output  1  sticky: WB retired a register whose count was 0

Behaviour:
- State: count[1..NUM_REGS-1], each CNT_W bits; StallCycles; Underflow.
- Reset (async, active-high): all counts=0, StallCycles=0, Underflow=0.
  - Outputs during reset: Stall=0, PendingMask=0.
  - Reset mid-operation discards all in-flight tracking.
- issue_fire = IssueValid & IssueRegWrite & ~Stall & (IssueWriteReg != 0).
- retire = WB_RegWrite & (WB_WriteReg != 0).
- Per register r, next-state:
  - issue_fire to r only: count+1.
  - retire of r only, count>0: count-1.
  - retire of r only, count==0: count unchanged; Underflow<=1.
  - Both on the same r in one cycle: count unchanged (net zero); Underflow not set even if count==0.
  - Issue and retire on different registers: apply both independently.
- Stall (combinational from state and inputs) = IssueValid & (hazRs | hazRt | destSat):
  - hazRs = UseRs & SrcRs != 0 & busy(SrcRs).
  - hazRt = UseRt & SrcRt != 0 & busy(SrcRt).
  - destSat = IssueRegWrite & IssueWriteReg != 0 & count[IssueWriteReg] == max.
  - busy(r) = count[r] != 0, subject to the optional feature.
- Register 0: reads never hazard, writes never tracked.
- Stall has no path from Stall back into issue except via issue_fire; no combinational loop.
- Flush (synchronous, priority below Reset, above issue/retire): all counts=0 next cycle.
  - Underflow and StallCycles are retained.
  - The issue/retire in a flush cycle are ignored.
- StallCycles increments each cycle Stall=1 and saturates at all-ones; it is not cleared by Flush.
- Latency:
  - An issued write appears in PendingMask the cycle after issue_fire.
  - A retire clears it the cycle after WB.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: busy(r) = count[r] != 0 & ~(retire & WB_WriteReg == r & count[r] == 1).
  - A source whose last pending write retires this cycle does not stall; the register file writes before the ID read.
  - Saves one stall cycle per RAW hazard.
- Undefined: busy(r) = count[r] != 0; the ID instruction stalls through the WB cycle and issues the following cycle.

Test Plan:
- Reset with Reset=1 at cycle 3 while count[8]=2 -> PendingMask=0, Stall=0 immediately, Underflow=0.
- Issue add $t0 (dest 8); next cycle issue sub reading rs=8, UseRs=1 -> Stall=1 until WB_RegWrite=1, WB_WriteReg=8:
  - with WB_BYPASS_EN: Stall=0 in that WB cycle.
  - without: Stall=0 in the following cycle.
  - StallCycles equals the stalled cycles.
- Issue writes to reg 9 three times without retire (CNT_W=2) -> fourth issue to 9 gives Stall=1 (destSat); one retire of 9 -> issue proceeds next cycle; PendingMask[9]=1 throughout.
- Same-cycle issue to 10 and retire of 10 with count[10]=1 -> count stays 1, PendingMask[10]=1, Underflow=0.
- WB_RegWrite=1, WB_WriteReg=12 with count[12]=0 -> Underflow=1 and sticky; Flush=1 -> PendingMask=0, Underflow still 1.
- Source/dest register 0 (UseRs=1, SrcRs=0; IssueWriteReg=0, repeated) -> Stall=0 always; PendingMask[0]=0.

Source files
------------

// File: rtl/wb_scoreboard.sv
// Register-write scoreboard: tracks in-flight destination writes between ID and WB and stalls ID on RAW or counter-full hazards.
// Optional macro WB_BYPASS_EN: a source whose last pending write retires this cycle is treated as ready.
module wb_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2,
    parameter int STAT_W   = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Flush,
    input  logic                IssueValid,
    input  logic                IssueRegWrite,
    input  logic [4:0]          IssueWriteReg,
    input  logic                UseRs,
    input  logic                UseRt,
    input  logic [4:0]          SrcRs,
    input  logic [4:0]          SrcRt,
    input  logic                WB_RegWrite,
    input  logic [4:0]          WB_WriteReg,
    output logic                Stall,
    output logic [NUM_REGS-1:0] PendingMask,
    output logic [STAT_W-1:0]   StallCycles,
    output logic                Underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]    count      [NUM_REGS];
    logic [CNT_W-1:0]    count_next [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                retire;
    logic                issue_fire;
    logic                haz_rs;
    logic                haz_rt;
    logic                dest_sat;
    logic                same_reg;
    logic                underflow_hit;

    assign retire = WB_RegWrite && (WB_WriteReg != 5'd0);

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = (r != 0) && (count[r] != '0);
`ifdef WB_BYPASS_EN
            if (retire && (WB_WriteReg == 5'(r)) && (count[r] == CNT_ONE)) begin
                busy[r] = 1'b0;
            end
`endif
        end
    end

    assign haz_rs     = UseRs && (SrcRs != 5'd0) && busy[SrcRs];
    assign haz_rt     = UseRt && (SrcRt != 5'd0) && busy[SrcRt];
    assign dest_sat   = IssueRegWrite && (IssueWriteReg != 5'd0) && (count[IssueWriteReg] == CNT_MAX);
    assign Stall      = IssueValid && (haz_rs || haz_rt || dest_sat);
    assign issue_fire = IssueValid && IssueRegWrite && !Stall && (IssueWriteReg != 5'd0);

    // An issue and a retire of the same register cancel out, even at count zero.
    assign same_reg      = issue_fire && retire && (IssueWriteReg == WB_WriteReg);
    assign underflow_hit = retire && !same_reg && !Flush && (count[WB_WriteReg] == '0);

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            count_next[r] = count[r];
            if (Flush) begin
                count_next[r] = '0;
            end else if (!same_reg) begin
                if (issue_fire && (IssueWriteReg == 5'(r))) begin
                    count_next[r] = count[r] + CNT_ONE;
                end
                if (retire && (WB_WriteReg == 5'(r)) && (count[r] != '0)) begin
                    count_next[r] = count[r] - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                count[r] <= '0;
            end
            StallCycles <= '0;
            Underflow   <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                count[r] <= count_next[r];
            end
            if (Stall && (StallCycles != '1)) begin
                StallCycles <= StallCycles + STAT_W'(1);
            end
            if (underflow_hit) begin
                Underflow <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            PendingMask[r] = (count[r] != '0);
        end
    end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard: directed vector table, hand-written corner sequences and a randomized run against a queue-free array model.
module tb_wb_scoreboard;

    localparam int NR   = 32;
    localparam int CMAX = 3;
    localparam int SMAX = 65535;

    logic        Clk = 1'b0;
    logic        Reset, Flush, IssueValid, IssueRegWrite, UseRs, UseRt, WB_RegWrite;
    logic [4:0]  IssueWriteReg, SrcRs, SrcRt, WB_WriteReg;
    logic        Stall;
    logic [31:0] PendingMask;
    logic [15:0] StallCycles;
    logic        Underflow;

    always #5 Clk = ~Clk;

    wb_scoreboard dut (
        .Clk(Clk), .Reset(Reset), .Flush(Flush),
        .IssueValid(IssueValid), .IssueRegWrite(IssueRegWrite), .IssueWriteReg(IssueWriteReg),
        .UseRs(UseRs), .UseRt(UseRt), .SrcRs(SrcRs), .SrcRt(SrcRt),
        .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg),
        .Stall(Stall), .PendingMask(PendingMask), .StallCycles(StallCycles), .Underflow(Underflow)
    );

    int   n_vec  = 0;
    int   n_fail = 0;
    int   m_cnt [NR];
    int   m_sc;
    bit   m_uf;
    logic dut_stall;

    typedef struct {
        int fl, iv, irw, wr, urs, urt, rs, rt, wbwe, wbreg;
        logic        e_stall;
        logic [31:0] e_mask;
        logic        e_uf;
    } vec_t;

    vec_t tbl [12];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int r = 0; r < NR; r++) m_cnt[r] = 0;
        m_sc = 0;
        m_uf = 0;
    endfunction

    // A register is a hazard source while it has writes outstanding.
    function automatic bit m_busy(int r);
        bit b;
        b = (r != 0) && (m_cnt[r] != 0);
`ifdef WB_BYPASS_EN
        if (WB_RegWrite && int'(WB_WriteReg) == r && m_cnt[r] == 1) b = 0;
`endif
        return b;
    endfunction

    function automatic bit m_stall();
        bit h;
        h = (UseRs && SrcRs != 0 && m_busy(int'(SrcRs))) ||
            (UseRt && SrcRt != 0 && m_busy(int'(SrcRt))) ||
            (IssueRegWrite && IssueWriteReg != 0 && m_cnt[IssueWriteReg] == CMAX);
        return IssueValid && h;
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m;
        m = '0;
        for (int r = 1; r < NR; r++) m[r] = (m_cnt[r] != 0);
        return m;
    endfunction

    function automatic void m_update(bit st);
        bit fire, ret;
        int wr, wb;
        wr   = int'(IssueWriteReg);
        wb   = int'(WB_WriteReg);
        fire = IssueValid && IssueRegWrite && !st && wr != 0;
        ret  = WB_RegWrite && wb != 0;
        if (st && m_sc < SMAX) m_sc++;
        if (Flush) begin
            for (int r = 0; r < NR; r++) m_cnt[r] = 0;
        end else if (!(fire && ret && wr == wb)) begin
            if (fire) m_cnt[wr]++;
            if (ret) begin
                if (m_cnt[wb] > 0) m_cnt[wb]--;
                else m_uf = 1;
            end
        end
    endfunction

    // One clock cycle: drive, check Stall before the edge, check state after it.
    task automatic applyStimulus(input int fl, input int iv, input int irw, input int wr,
                                 input int urs, input int urt, input int rs, input int rt,
                                 input int wbwe, input int wbreg);
        bit st;
        Flush = fl[0]; IssueValid = iv[0]; IssueRegWrite = irw[0]; IssueWriteReg = wr[4:0];
        UseRs = urs[0]; UseRt = urt[0]; SrcRs = rs[4:0]; SrcRt = rt[4:0];
        WB_RegWrite = wbwe[0]; WB_WriteReg = wbreg[4:0];
        #1;
        st = m_stall();
        dut_stall = Stall;
        checkOutput("stall", {31'b0, Stall}, {31'b0, st});
        @(posedge Clk);
        m_update(st);
        #1;
        checkOutput("pending_mask", PendingMask, m_mask());
        checkOutput("underflow", {31'b0, Underflow}, {31'b0, m_uf});
        checkOutput("stall_cycles", {16'b0, StallCycles}, m_sc);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        m_reset();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    function automatic vec_t mk(int fl, int iv, int irw, int wr, int urs, int urt, int rs, int rt,
                                int wbwe, int wbreg, logic es, logic [31:0] em, logic eu);
        vec_t v;
        v.fl = fl; v.iv = iv; v.irw = irw; v.wr = wr; v.urs = urs; v.urt = urt;
        v.rs = rs; v.rt = rt; v.wbwe = wbwe; v.wbreg = wbreg;
        v.e_stall = es; v.e_mask = em; v.e_uf = eu;
        return v;
    endfunction

    initial begin
        int exp_sc;
        Reset = 1'b1; Flush = 0; IssueValid = 0; IssueRegWrite = 0; IssueWriteReg = 0;
        UseRs = 0; UseRt = 0; SrcRs = 0; SrcRt = 0; WB_RegWrite = 0; WB_WriteReg = 0;
        m_reset();
        @(posedge Clk);
        @(posedge Clk);
        #1;
        checkOutput("reset_mask", PendingMask, 32'h0);
        checkOutput("reset_stall", {31'b0, Stall}, 32'h0);
        checkOutput("reset_sc", {16'b0, StallCycles}, 32'h0);
        checkOutput("reset_uf", {31'b0, Underflow}, 32'h0);
        Reset = 1'b0;

        // Saturation of reg 9, same-cycle issue/retire of 10, underflow on 12, flush, reg 0.
        tbl[0]  = mk(0, 1, 1, 9,  0, 0, 0, 0, 0, 0,  1'b0, 32'h200, 1'b0);
        tbl[1]  = mk(0, 1, 1, 9,  0, 0, 0, 0, 0, 0,  1'b0, 32'h200, 1'b0);
        tbl[2]  = mk(0, 1, 1, 9,  0, 0, 0, 0, 0, 0,  1'b0, 32'h200, 1'b0);
        tbl[3]  = mk(0, 1, 1, 9,  0, 0, 0, 0, 0, 0,  1'b1, 32'h200, 1'b0);
        tbl[4]  = mk(0, 1, 1, 9,  0, 0, 0, 0, 1, 9,  1'b1, 32'h200, 1'b0);
        tbl[5]  = mk(0, 1, 1, 9,  0, 0, 0, 0, 0, 0,  1'b0, 32'h200, 1'b0);
        tbl[6]  = mk(0, 1, 1, 10, 0, 0, 0, 0, 0, 0,  1'b0, 32'h600, 1'b0);
        tbl[7]  = mk(0, 1, 1, 10, 0, 0, 0, 0, 1, 10, 1'b0, 32'h600, 1'b0);
        tbl[8]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 12, 1'b0, 32'h600, 1'b1);
        tbl[9]  = mk(1, 1, 1, 11, 0, 0, 0, 0, 1, 9,  1'b0, 32'h0,   1'b1);
        tbl[10] = mk(0, 1, 1, 0,  1, 0, 0, 0, 0, 0,  1'b0, 32'h0,   1'b1);
        tbl[11] = mk(0, 1, 1, 0,  1, 1, 0, 0, 0, 0,  1'b0, 32'h0,   1'b1);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i].fl, tbl[i].iv, tbl[i].irw, tbl[i].wr, tbl[i].urs, tbl[i].urt,
                          tbl[i].rs, tbl[i].rt, tbl[i].wbwe, tbl[i].wbreg);
            checkOutput($sformatf("tbl%0d_stall", i), {31'b0, dut_stall}, {31'b0, tbl[i].e_stall});
            checkOutput($sformatf("tbl%0d_mask", i), PendingMask, tbl[i].e_mask);
            checkOutput($sformatf("tbl%0d_uf", i), {31'b0, Underflow}, {31'b0, tbl[i].e_uf});
        end
        checkOutput("tbl_stall_cycles", {16'b0, StallCycles}, 32'd2);

        // RAW hazard on reg 8 resolved by the WB retire.
        do_reset();
        applyStimulus(0, 1, 1, 8, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 1, 13, 1, 0, 8, 0, 0, 0);
            checkOutput("raw_stall", {31'b0, dut_stall}, 32'd1);
        end
        applyStimulus(0, 1, 1, 13, 1, 0, 8, 0, 1, 8);
`ifdef WB_BYPASS_EN
        checkOutput("raw_wb_stall", {31'b0, dut_stall}, 32'd0);
        exp_sc = 3;
`else
        checkOutput("raw_wb_stall", {31'b0, dut_stall}, 32'd1);
        applyStimulus(0, 1, 1, 13, 1, 0, 8, 0, 0, 0);
        checkOutput("raw_after_stall", {31'b0, dut_stall}, 32'd0);
        exp_sc = 4;
`endif
        checkOutput("raw_stall_cycles", {16'b0, StallCycles}, exp_sc);
        checkOutput("raw_mask", PendingMask, 32'h2000);

        // Asynchronous reset mid-cycle while reg 8 has two writes pending.
        do_reset();
        applyStimulus(0, 1, 1, 8, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 8, 0, 0, 0, 0, 0, 0);
        IssueValid = 1; IssueRegWrite = 0; UseRs = 1; SrcRs = 5'd8;
        #1;
        checkOutput("pre_reset_stall", {31'b0, Stall}, 32'd1);
        Reset = 1'b1;
        #1;
        m_reset();
        checkOutput("async_reset_stall", {31'b0, Stall}, 32'd0);
        checkOutput("async_reset_mask", PendingMask, 32'h0);
        checkOutput("async_reset_uf", {31'b0, Underflow}, 32'h0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Randomized run over a small register window to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 31) == 0) ? 1 : 0,
                          ($urandom_range(0, 7) != 0) ? 1 : 0,
                          int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 5)),
                          int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 5)),
                          int'($urandom_range(0, 5)),
                          ($urandom_range(0, 2) != 0) ? 1 : 0,
                          int'($urandom_range(0, 5)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
